ov7670_config_sequencer: RTL
============================

# ov7670_config_sequencer

Walks a register table held in an external synchronous ROM and issues one SCCB register write per entry to the `sender` block, which serialises each write onto SIOC/SIOD. It sits between camera bring-up control and `sender`: it supplies `id`/`regis`/`value`, holds `send` until `sender` pulses `taken`, and inserts table-coded delays, for example after the OV7670 soft reset (reg 0x12 = 0x80). It reports `busy`, `done` and a handshake-timeout `error`.

## Interface
- `DEV_ID`, 8'h42, SCCB write device address driven on `id`.
- `ADDR_W`, 8, ROM address width.
- `DELAY_UNIT`, 25000, clk cycles per delay unit (1 ms at 25 MHz).
- `TAKEN_TIMEOUT`, 65535, max cycles in SEND without `taken` before error.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level/pulse; begins sequence from entry 0 when not busy.
- `rom_addr`  out  ADDR_W  table address.
- `rom_data`  in  16  table entry {reg[15:8], val[7:0]}, valid 1 cycle after `rom_addr`.
- `id`  out  8  to sender, constant `DEV_ID`.
- `regis`  out  8  to sender, register address.
- `value`  out  8  to sender, register data.
- `send`  out  1  to sender, write request.
- `taken`  in  1  from sender, 1-cycle accept pulse.
- `busy`  out  1  sequence in progress.
- `done`  out  1  sticky, table completed.
- `error`  out  1  sticky, `taken` timeout.

## Operation
- States: IDLE, FETCH, DECODE, SEND, DELAY, DONE, ERROR.
- Reset values: state IDLE, `rom_addr`=0, `regis`=0, `value`=0, `send`=0, `busy`=0, `done`=0, `error`=0, `id`=`DEV_ID`, counters 0. Reset mid-sequence aborts at once; `send` drops asynchronously.
- IDLE/DONE/ERROR with `start`=1: clear `done`/`error`, `rom_addr`<=0, `busy`<=1, go to FETCH. `start` is ignored while `busy`=1.
- FETCH: hold `rom_addr` for one cycle, then go to DECODE.
- DECODE samples `rom_data` and selects one of:
  - 16'hFFFF: end marker. Go to DONE, `done`<=1, `busy`<=0.
  - reg=8'hFF, val≠8'hFF: delay entry. If val=0, advance immediately. Otherwise load delay count = val×`DELAY_UNIT`−1 (32-bit) and go to DELAY.
  - Anything else: write entry. `regis`<=reg, `value`<=val, `send`<=1, timeout counter<=0, go to SEND.
- SEND: `send` is held high, `regis`/`value` stay stable.
  - On `taken`=1: `send`<=0, advance.
  - If timeout counter reaches `TAKEN_TIMEOUT` first: `send`<=0, `error`<=1, `busy`<=0, go to ERROR.
- DELAY: decrement the count each cycle. At 0, advance.
- Advance rule: if `rom_addr`=2^ADDR_W−1, treat as end of table (DONE, no wrap). Otherwise `rom_addr`<=`rom_addr`+1 and go to FETCH.
- `taken` outside SEND is ignored. `regis`/`value` keep their last written entry after DONE/ERROR.

## Timing
- `start` sampled at edge N gives FETCH after N. DECODE follows after N+1. For a write entry, `send`=1 after N+2.
- Each write costs 3 cycles of overhead plus the sender's accept wait. `taken` sampled at edge M gives `send`=0 after M. The next `rom_addr` is valid after M, and the next `send` rises after M+2.
- `send` is deasserted in the same edge that samples `taken`, so `sender` accepts exactly one frame per entry even though `taken` is registered.
- A delay entry with val=k occupies exactly k×`DELAY_UNIT` cycles in DELAY, plus FETCH/DECODE overhead.
- `done`/`error` assert in the same edge that `busy` falls. They stay high until `start` or `rst`.

## Test plan
- Table {12 80, FF 01, 11 01, FFFF} with `DELAY_UNIT`=10 and a sender model giving `taken` 5 cycles after `send`:
  - Two writes are issued, (0x12,0x80) then (0x11,0x01).
  - Exactly 10 DELAY cycles occur between them.
  - `done`=1 and `busy`=0 after the end marker, with `rom_addr`=3.
- `taken` never asserted, `TAKEN_TIMEOUT`=20: `send` drops and `error`=1 after 21 SEND cycles, `busy`=0. A following `start` clears `error` and restarts at addr 0.
- `start` pulsed while in SEND: no effect. `rom_addr` and `regis` are unchanged, and the sequence completes normally.
- `rst` asserted while `send`=1: `send`, `busy` and `rom_addr` go to 0 immediately without a clock edge. After release, IDLE holds until `start`.
- `ADDR_W`=2 with table {0A 01, 0B 02, 0C 03, 0D 04} and no end marker: four writes, then `done`=1 with `rom_addr`=3 (no wrap). Delay entry FF00 is skipped with no DELAY state.

Source files
------------

// File: rtl/ov7670_config_sequencer.sv
// OV7670 register-table sequencer: walks a synchronous ROM of {reg,val}
// entries and hands each write to the SCCB sender, with table-coded delays,
// an end marker and a handshake timeout.
module ov7670_config_sequencer #(
  parameter logic [7:0] DEV_ID        = 8'h42,
  parameter int         ADDR_W        = 8,
  parameter int         DELAY_UNIT    = 25000,
  parameter int         TAKEN_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        id,
  output logic [7:0]        regis,
  output logic [7:0]        value,
  output logic              send,
  input  logic              taken,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, SEND, DELAY, DONE, ERROR} state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [31:0]       UNIT      = 32'(DELAY_UNIT);
  localparam logic [31:0]       TMO       = 32'(TAKEN_TIMEOUT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        regis_q, regis_d, value_q, value_d;
  logic              send_q, send_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [31:0]       dcnt_q, dcnt_d, tcnt_q, tcnt_d;
  logic              adv;

  assign rom_addr = addr_q;
  assign id       = DEV_ID;
  assign regis    = regis_q;
  assign value    = value_q;
  assign send     = send_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

  // State and output registers; reset clears everything, so send drops without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      regis_q <= '0;
      value_q <= '0;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      dcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      regis_q <= regis_d;
      value_q <= value_d;
      send_q  <= send_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      dcnt_q  <= dcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Next-state logic; 'adv' funnels every "entry finished" path into one advance rule.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    regis_d = regis_q;
    value_d = value_q;
    send_d  = send_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    dcnt_d  = dcnt_q;
    tcnt_d  = tcnt_q;
    adv     = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end
      // ROM is registered: address presented here, data sampled in DECODE.
      FETCH: state_d = DECODE;
      DECODE: begin
        if (rom_data == 16'hFFFF) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (rom_data[15:8] == 8'hFF) begin
          if (rom_data[7:0] == 8'h00) begin
            adv = 1'b1;
          end else begin
            // Count down to 0 inclusive gives exactly val*DELAY_UNIT cycles in DELAY.
            dcnt_d  = 32'(rom_data[7:0]) * UNIT - 32'd1;
            state_d = DELAY;
          end
        end else begin
          regis_d = rom_data[15:8];
          value_d = rom_data[7:0];
          send_d  = 1'b1;
          tcnt_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (taken) begin
          send_d = 1'b0;
          adv    = 1'b1;
        end else if (tcnt_q == TMO) begin
          send_d  = 1'b0;
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ERROR;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end
      DELAY: begin
        if (dcnt_q == '0) adv = 1'b1;
        else              dcnt_d = dcnt_q - 32'd1;
      end
      default: state_d = IDLE;
    endcase

    // Last ROM address ends the table instead of wrapping.
    if (adv) begin
      if (addr_q == ADDR_LAST) begin
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = FETCH;
      end
    end
  end

endmodule
